// File: rtl/cpu_control_unit_pkg.sv
// Shared definitions for the fetch/decode/control stage: opcodes, ALU op codes,
// FSM state encoding and default geometry.
package cpu_control_unit_pkg;

  localparam int PC_W_DEF    = 32;
  localparam int INSTR_W_DEF = 32;
  localparam int RADDR_W_DEF = 3;
  localparam int DATA_W_DEF  = 8;
  localparam int PC_STEP_DEF = 4;

  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;
  localparam logic [7:0] OP_J     = 8'h06;
  localparam logic [7:0] OP_BEQ   = 8'h07;

  typedef enum logic [2:0] {
    ALU_FWD = 3'd0,
    ALU_ADD = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2
  } state_e;

endpackage

// File: rtl/cpu_instr_decoder.sv
// Purely combinational opcode decoder: ALU control, operand muxing, write
// enable and control-flow class of one instruction.
module cpu_instr_decoder
  import cpu_control_unit_pkg::*;
(
  input  logic [7:0] opcode,
  output alu_op_e    aluop,
  output logic       imm_sel,
  output logic       neg_sel,
  output logic       writes,
  output logic       is_jump,
  output logic       is_beq,
  output logic       illegal
);

  // opcode table; anything unlisted behaves as a NOP and is flagged
  always_comb begin
    aluop   = ALU_FWD;
    imm_sel = 1'b0;
    neg_sel = 1'b0;
    writes  = 1'b0;
    is_jump = 1'b0;
    is_beq  = 1'b0;
    illegal = 1'b0;
    case (opcode)
      OP_LOADI: begin
        imm_sel = 1'b1;
        writes  = 1'b1;
      end
      OP_MOV: begin
        writes = 1'b1;
      end
      OP_ADD: begin
        aluop  = ALU_ADD;
        writes = 1'b1;
      end
      OP_SUB: begin
        aluop   = ALU_ADD;
        neg_sel = 1'b1;
        writes  = 1'b1;
      end
      OP_AND: begin
        aluop  = ALU_AND;
        writes = 1'b1;
      end
      OP_OR: begin
        aluop  = ALU_OR;
        writes = 1'b1;
      end
      OP_J: begin
        is_jump = 1'b1;
      end
      OP_BEQ: begin
        aluop   = ALU_ADD;
        neg_sel = 1'b1;
        is_beq  = 1'b1;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/cpu_control_unit.sv
// Fetch/decode/control stage: holds the IR, the FETCH->DECODE->EXEC FSM and
// the PC, and drives register-file addresses and ALU controls from flops.
module cpu_control_unit
  import cpu_control_unit_pkg::*;
#(
  parameter int PC_W    = PC_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int RADDR_W = RADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int PC_STEP = PC_STEP_DEF
) (
  input  logic               CLK,
  input  logic               RESET,
  output logic [PC_W-1:0]    PC,
  input  logic [INSTR_W-1:0] INSTR,
  input  logic               INSTR_VALID,
  output logic               INSTR_READY,
  input  logic               ZERO,
  output logic [RADDR_W-1:0] READREG1,
  output logic [RADDR_W-1:0] READREG2,
  output logic [RADDR_W-1:0] WRITEREG,
  output logic               WRITEENABLE,
  output logic [DATA_W-1:0]  IMMEDIATE,
  output logic [2:0]         ALUOP,
  output logic               IMM_SEL,
  output logic               NEG_SEL,
  output logic               ILLEGAL
);

  localparam logic [PC_W-1:0] STEP = PC_W'(PC_STEP);

  state_e              state_r, state_nxt_s;
  logic [INSTR_W-1:0]  ir_r;
  logic [PC_W-1:0]     pc_r, pc_inc_s, pc_tgt_s, pc_nxt_s;
  logic [RADDR_W-1:0]  readreg1_r, readreg2_r, writereg_r;
  logic [DATA_W-1:0]   imm_r;
  alu_op_e             aluop_r;
  logic                imm_sel_r, neg_sel_r, we_r, illegal_r;
  logic                writes_r, is_jump_r, is_beq_r, illegal_pend_r;
  alu_op_e             dec_aluop_s;
  logic                dec_imm_sel_s, dec_neg_sel_s, dec_writes_s;
  logic                dec_is_jump_s, dec_is_beq_s, dec_illegal_s;
  logic                unused_ir_s;

  // Decode the incoming word so every control lands in a flop at the accept edge
  cpu_instr_decoder u_dec (
    .opcode  (INSTR[31:24]),
    .aluop   (dec_aluop_s),
    .imm_sel (dec_imm_sel_s),
    .neg_sel (dec_neg_sel_s),
    .writes  (dec_writes_s),
    .is_jump (dec_is_jump_s),
    .is_beq  (dec_is_beq_s),
    .illegal (dec_illegal_s)
  );

  // FSM state register
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r <= ST_FETCH;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state: one instruction in flight, three cycles minimum
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_FETCH: begin
        if (INSTR_VALID) begin
          state_nxt_s = ST_DECODE;
        end else begin
          state_nxt_s = ST_FETCH;
        end
      end
      ST_DECODE: state_nxt_s = ST_EXEC;
      ST_EXEC:   state_nxt_s = ST_FETCH;
      default:   state_nxt_s = ST_FETCH;
    endcase
  end

  // Next PC: branch offset is a signed word count relative to PC+STEP
  always_comb begin
    pc_inc_s = pc_r + STEP;
    pc_tgt_s = pc_inc_s + {{(PC_W-10){ir_r[23]}}, ir_r[23:16], 2'b00};
    if (is_jump_r || (is_beq_r && ZERO)) begin
      pc_nxt_s = pc_tgt_s;
    end else begin
      pc_nxt_s = pc_inc_s;
    end
  end

  // IR, PC and registered control outputs
  always_ff @(posedge CLK) begin
    if (RESET) begin
      ir_r           <= '0;
      pc_r           <= '0;
      readreg1_r     <= '0;
      readreg2_r     <= '0;
      writereg_r     <= '0;
      imm_r          <= '0;
      aluop_r        <= ALU_FWD;
      imm_sel_r      <= 1'b0;
      neg_sel_r      <= 1'b0;
      we_r           <= 1'b0;
      illegal_r      <= 1'b0;
      writes_r       <= 1'b0;
      is_jump_r      <= 1'b0;
      is_beq_r       <= 1'b0;
      illegal_pend_r <= 1'b0;
    end else begin
      case (state_r)
        ST_FETCH: begin
          if (INSTR_VALID) begin
            ir_r           <= INSTR;
            readreg1_r     <= INSTR[8 +: RADDR_W];
            readreg2_r     <= INSTR[0 +: RADDR_W];
            writereg_r     <= INSTR[16 +: RADDR_W];
            imm_r          <= INSTR[0 +: DATA_W];
            aluop_r        <= dec_aluop_s;
            imm_sel_r      <= dec_imm_sel_s;
            neg_sel_r      <= dec_neg_sel_s;
            writes_r       <= dec_writes_s;
            is_jump_r      <= dec_is_jump_s;
            is_beq_r       <= dec_is_beq_s;
            illegal_pend_r <= dec_illegal_s;
          end
        end
        ST_DECODE: begin
          we_r      <= writes_r;
          illegal_r <= illegal_pend_r;
        end
        ST_EXEC: begin
          // retire: PC advances and controls drop so nothing stale leaks into FETCH
          pc_r       <= pc_nxt_s;
          we_r       <= 1'b0;
          illegal_r  <= 1'b0;
          readreg1_r <= '0;
          readreg2_r <= '0;
          writereg_r <= '0;
          imm_r      <= '0;
          aluop_r    <= ALU_FWD;
          imm_sel_r  <= 1'b0;
          neg_sel_r  <= 1'b0;
        end
        default: begin
          we_r      <= 1'b0;
          illegal_r <= 1'b0;
        end
      endcase
    end
  end

  // IR is kept whole for visibility; only its offset byte feeds the PC adder
  assign unused_ir_s = ^ir_r;

  assign INSTR_READY = (state_r == ST_FETCH) && !RESET;
  assign PC          = pc_r;
  assign READREG1    = readreg1_r;
  assign READREG2    = readreg2_r;
  assign WRITEREG    = writereg_r;
  assign WRITEENABLE = we_r;
  assign IMMEDIATE   = imm_r;
  assign ALUOP       = aluop_r;
  assign IMM_SEL     = imm_sel_r;
  assign NEG_SEL     = neg_sel_r;
  assign ILLEGAL     = illegal_r;

endmodule

// File: tb/tb_cpu_control_unit.sv
// Directed self-checking bench for cpu_control_unit: reset, each opcode class,
// branch taken/not taken, PC wrap, stalled fetch and illegal opcode.
module tb_cpu_control_unit;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] PC;
  logic [31:0] INSTR;
  logic        INSTR_VALID;
  logic        INSTR_READY;
  logic        ZERO;
  logic [2:0]  READREG1, READREG2, WRITEREG;
  logic        WRITEENABLE;
  logic [7:0]  IMMEDIATE;
  logic [2:0]  ALUOP;
  logic        IMM_SEL, NEG_SEL, ILLEGAL;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  always #5 CLK = ~CLK;

  cpu_control_unit dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .PC          (PC),
    .INSTR       (INSTR),
    .INSTR_VALID (INSTR_VALID),
    .INSTR_READY (INSTR_READY),
    .ZERO        (ZERO),
    .READREG1    (READREG1),
    .READREG2    (READREG2),
    .WRITEREG    (WRITEREG),
    .WRITEENABLE (WRITEENABLE),
    .IMMEDIATE   (IMMEDIATE),
    .ALUOP       (ALUOP),
    .IMM_SEL     (IMM_SEL),
    .NEG_SEL     (NEG_SEL),
    .ILLEGAL     (ILLEGAL)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (INSTR_READY !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check_val({tag, "_ready"}, {31'd0, INSTR_READY}, 32'd1);
  endtask

  // One full instruction: accept, DECODE checks, EXEC checks, retire checks
  task automatic run_instr(input string tag, input logic [31:0] instr, input logic zero,
                           input logic [2:0] aluop, input logic imm_sel, input logic neg_sel,
                           input logic we, input logic ill, input logic [31:0] next_pc);
    wait_ready(tag);
    INSTR       = instr;
    INSTR_VALID = 1'b1;
    tick();
    INSTR_VALID = 1'b0;
    INSTR       = 32'hFFFF_FFFF;
    ZERO        = zero;
    #1;
    check_val({tag, "_dec_ready"}, {31'd0, INSTR_READY}, 32'd0);
    check_val({tag, "_dec_we"},    {31'd0, WRITEENABLE}, 32'd0);
    check_val({tag, "_dec_ill"},   {31'd0, ILLEGAL},     32'd0);
    check_val({tag, "_rr1"},       {29'd0, READREG1},    {29'd0, instr[10:8]});
    check_val({tag, "_rr2"},       {29'd0, READREG2},    {29'd0, instr[2:0]});
    check_val({tag, "_wr"},        {29'd0, WRITEREG},    {29'd0, instr[18:16]});
    check_val({tag, "_imm"},       {24'd0, IMMEDIATE},   {24'd0, instr[7:0]});
    check_val({tag, "_aluop"},     {29'd0, ALUOP},       {29'd0, aluop});
    check_val({tag, "_immsel"},    {31'd0, IMM_SEL},     {31'd0, imm_sel});
    check_val({tag, "_negsel"},    {31'd0, NEG_SEL},     {31'd0, neg_sel});
    tick();
    check_val({tag, "_exec_we"},    {31'd0, WRITEENABLE}, {31'd0, we});
    check_val({tag, "_exec_ill"},   {31'd0, ILLEGAL},     {31'd0, ill});
    check_val({tag, "_exec_aluop"}, {29'd0, ALUOP},       {29'd0, aluop});
    check_val({tag, "_exec_wr"},    {29'd0, WRITEREG},    {29'd0, instr[18:16]});
    tick();
    check_val({tag, "_pc"},      PC,                   next_pc);
    check_val({tag, "_ret_we"},  {31'd0, WRITEENABLE}, 32'd0);
    check_val({tag, "_ret_ill"}, {31'd0, ILLEGAL},     32'd0);
    ZERO = 1'b0;
  endtask

  initial begin
    RESET       = 1'b1;
    INSTR       = 32'd0;
    INSTR_VALID = 1'b0;
    ZERO        = 1'b0;
    tick();
    tick();
    check_val("rst_pc",    PC,                   32'd0);
    check_val("rst_ready", {31'd0, INSTR_READY}, 32'd0);
    check_val("rst_we",    {31'd0, WRITEENABLE}, 32'd0);
    RESET = 1'b0;
    #1;
    check_val("post_rst_ready", {31'd0, INSTR_READY}, 32'd1);

    // loadi r2,#95
    run_instr("loadi", 32'h0002_005F, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd4);

    // add r1,r2,r3 interrupted by a 2-cycle reset in EXEC
    wait_ready("add_rst");
    INSTR       = 32'h0201_0203;
    INSTR_VALID = 1'b1;
    tick();
    INSTR_VALID = 1'b0;
    tick();
    check_val("add_exec_we", {31'd0, WRITEENABLE}, 32'd1);
    RESET = 1'b1;
    tick();
    check_val("midrst_pc",    PC,                   32'd0);
    check_val("midrst_we",    {31'd0, WRITEENABLE}, 32'd0);
    check_val("midrst_ready", {31'd0, INSTR_READY}, 32'd0);
    tick();
    RESET = 1'b0;
    #1;
    check_val("after_rst_ready", {31'd0, INSTR_READY}, 32'd1);
    check_val("after_rst_pc",    PC,                   32'd0);
    check_val("after_rst_we",    {31'd0, WRITEENABLE}, 32'd0);

    run_instr("loadi2", 32'h0001_0007, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd4);
    run_instr("sub",    32'h0303_0102, 1'b0, 3'd1, 1'b0, 1'b1, 1'b1, 1'b0, 32'd8);
    run_instr("beq_t",  32'h07FE_0102, 1'b1, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd4);
    run_instr("and",    32'h0404_0102, 1'b0, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 32'd8);
    run_instr("beq_nt", 32'h07FE_0102, 1'b0, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd12);
    run_instr("or",     32'h0505_0102, 1'b0, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 32'd16);
    run_instr("mov",    32'h0106_0100, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd20);

    // stalled fetch: INSTR present but not valid
    INSTR = 32'h0207_0102;
    for (int i = 0; i < 5; i++) begin
      tick();
    end
    check_val("stall_pc",    PC,                   32'd20);
    check_val("stall_ready", {31'd0, INSTR_READY}, 32'd1);
    check_val("stall_we",    {31'd0, WRITEENABLE}, 32'd0);

    run_instr("illegal", 32'hFF01_0203, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd24);

    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    #1;
    check_val("rst2_pc", PC, 32'd0);
    run_instr("j_back", 32'h06FE_0000, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC);
    run_instr("j_wrap", 32'h0602_0000, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0008);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
